// File: rtl/ctr_reload_seq.sv
// ctr_reload_seq: prescaled count-enable, load strobe and reload/IRQ timing for a 4-bit-slice up-counter chain.
// Latency: LD is asserted the cycle after START; TC_IRQ is asserted the cycle after an accepted CO.
// Backpressure: none. EN low freezes the prescaler and RUN state and forces CI low, so the period stretches.
//
// Optional feature: define CTR_RELOAD_OVR_EN to add IRQ_ACK and a sticky OVR interrupt-overrun flag.
//
// Ports:
//   CK      rising-edge clock
//   RST     synchronous reset, active high
//   EN      global enable; low freezes the prescaler and RUN state and forces CI=0
//   START   single-cycle start/restart request (ignored while EN=0 and during LOAD)
//   MODE    0 = one-shot, 1 = periodic; sampled in LOAD
//   RELOAD  tick count minus 1; sampled in LOAD
//   PSC     prescale divisor minus 1; sampled in LOAD
//   CO      terminal carry-out of the chain (all ones AND CI)
//   CI      count enable / carry-in to the chain
//   LD      load strobe to the chain
//   D       load value, ~RELOAD during LOAD, otherwise 0
//   TC_IRQ  one-cycle terminal-count pulse
//   BUSY    high in LOAD and RUN
//   IRQ_ACK (optional) acknowledges a pending TC_IRQ
//   OVR     (optional) sticky; set when TC_IRQ fires while the previous one is still unacknowledged

module ctr_reload_seq #(
    parameter int WIDTH = 16,   // multiple of 4, one slice per nibble
    parameter int PSC_W = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             EN,
    input  logic             START,
    input  logic             MODE,
    input  logic [WIDTH-1:0] RELOAD,
    input  logic [PSC_W-1:0] PSC,
    input  logic             CO,
`ifdef CTR_RELOAD_OVR_EN
    input  logic             IRQ_ACK,
    output logic             OVR,
`endif
    output logic             CI,
    output logic             LD,
    output logic [WIDTH-1:0] D,
    output logic             TC_IRQ,
    output logic             BUSY
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PSC_W-1:0] p_q, p_d;
    logic [PSC_W-1:0] psc_q;
    logic             mode_q;
    logic             irq_q, irq_d;

    logic tick;
    logic co_acc;
    logic start_ok;

    // The chain holds the loaded count, so only PSC and MODE need to be kept here.
    assign tick     = (state_q == S_RUN) && EN && (p_q == psc_q);
    // CO is only meaningful while we are actually enabling the chain.
    assign co_acc   = tick && CO;
    assign start_ok = START && EN;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        irq_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                p_d = '0;
                if (start_ok) state_d = S_LOAD;
            end
            S_LOAD: begin
                p_d     = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (EN) p_d = tick ? '0 : p_q + {{(PSC_W-1){1'b0}}, 1'b1};
                if (co_acc) begin
                    irq_d   = 1'b1;
                    state_d = mode_q ? S_LOAD : S_DONE;
                end
                // A restart overrides the terminal decision; the IRQ above still fires.
                if (start_ok) state_d = S_LOAD;
            end
            S_DONE: begin
                p_d     = '0;
                state_d = start_ok ? S_LOAD : S_IDLE;
            end
            default: begin
                p_d     = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            psc_q   <= '0;
            mode_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            irq_q   <= irq_d;
            if (state_q == S_LOAD) begin
                psc_q  <= PSC;
                mode_q <= MODE;
            end
        end
    end

    assign LD     = (state_q == S_LOAD);
    assign CI     = tick;
    // Chain counts up to all-ones, so loading ~RELOAD gives RELOAD+1 ticks to terminal.
    assign D      = LD ? ~RELOAD : '0;
    assign TC_IRQ = irq_q;
    assign BUSY   = (state_q == S_LOAD) || (state_q == S_RUN);

`ifdef CTR_RELOAD_OVR_EN
    logic pend_q;
    logic ovr_q;

    // An ACK coinciding with a new TC_IRQ retires the old event; the new one stays pending.
    always_ff @(posedge CK) begin
        if (RST) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (irq_q)        pend_q <= 1'b1;
            else if (IRQ_ACK) pend_q <= 1'b0;
            if (irq_q && pend_q && !IRQ_ACK) ovr_q <= 1'b1;
        end
    end

    assign OVR = ovr_q;
`endif

endmodule

// File: tb/tb_ctr_reload_seq.sv
// tb_ctr_reload_seq: directed bench for ctr_reload_seq with a behavioural 16-bit counter chain.
// Latency: one vector per clock; outputs sampled 2 time units after the rising edge.
// Backpressure: none.
module tb_ctr_reload_seq;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b1;
    logic        START = 1'b0;
    logic        MODE = 1'b0;
    logic [15:0] RELOAD = 16'd0;
    logic [7:0]  PSC = 8'd0;
    logic        CO;
    logic        CI;
    logic        LD;
    logic [15:0] D;
    logic        TC_IRQ;
    logic        BUSY;
`ifdef CTR_RELOAD_OVR_EN
    logic        IRQ_ACK = 1'b0;
    logic        OVR;
`endif

    int n_tot = 0;
    int n_bad = 0;

    always #5 CK = ~CK;

    ctr_reload_seq #(.WIDTH(16), .PSC_W(8)) dut (
        .CK     (CK),
        .RST    (RST),
        .EN     (EN),
        .START  (START),
        .MODE   (MODE),
        .RELOAD (RELOAD),
        .PSC    (PSC),
        .CO     (CO),
`ifdef CTR_RELOAD_OVR_EN
        .IRQ_ACK(IRQ_ACK),
        .OVR    (OVR),
`endif
        .CI     (CI),
        .LD     (LD),
        .D      (D),
        .TC_IRQ (TC_IRQ),
        .BUSY   (BUSY)
    );

    // Behavioural counter chain: loads on LD, counts on CI, CO = all-ones AND CI.
    logic [15:0] q = 16'h0000;
    always @(posedge CK) begin
        if (LD)      q <= D;
        else if (CI) q <= q + 16'd1;
    end
    assign CO = (q == 16'hFFFF) & CI;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Expected vector order: {LD, CI, TC_IRQ, BUSY}
    task automatic ck_out(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, LD, CI, TC_IRQ, BUSY}, {28'd0, exp});
    endtask

    task automatic go();
        @(posedge CK);
        #1;
    endtask

    // Leaves RST low at the start of a cycle in which the DUT is IDLE.
    task automatic do_reset();
        RST   = 1'b1;
        START = 1'b0;
        EN    = 1'b1;
`ifdef CTR_RELOAD_OVR_EN
        IRQ_ACK = 1'b0;
`endif
        go();
        go();
        RST = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        go();
        go();
        #1;
        ck_out("rst_out", 4'b0000);
        chk("rst_d", {16'd0, D}, 32'd0);

        // ---------------- periodic: RELOAD=3 PSC=1, period 9 ----------------
        do_reset();
        MODE = 1'b1; RELOAD = 16'd3; PSC = 8'd1; START = 1'b1;
        #1;
        ck_out("p_idle", 4'b0000);
        go(); START = 1'b0; #1;
        ck_out("p_load", 4'b1001);
        chk("p_d", {16'd0, D}, {16'd0, 16'hFFFC});
        for (int per = 0; per < 2; per++) begin
            for (int k = 1; k <= 9; k++) begin
                go();
                // Mid-run change must not affect the current period, only the next load.
                if (per == 1 && k == 3) RELOAD = 16'd5;
                #1;
                if (k == 9) begin
                    ck_out("p_reload", 4'b1011);
                    chk("p_d_reload", {16'd0, D}, (per == 0) ? 32'h0000FFFC : 32'h0000FFFA);
                end else begin
                    ck_out("p_run", {1'b0, (k % 2 == 0), 1'b0, 1'b1});
                end
            end
        end

        // ---------------- START with EN=0 is ignored ----------------
        do_reset();
        EN = 1'b0; START = 1'b1;
        go(); START = 1'b0; EN = 1'b1; #1;
        ck_out("en0_start", 4'b0000);

        // ---------------- one-shot: RELOAD=0 PSC=0 ----------------
        do_reset();
        MODE = 1'b0; RELOAD = 16'd0; PSC = 8'd0; START = 1'b1;
        go(); START = 1'b0; #1;
        ck_out("o_load", 4'b1001);
        chk("o_d", {16'd0, D}, {16'd0, 16'hFFFF});
        go(); #1;
        ck_out("o_run", 4'b0101);
        chk("o_co", {31'd0, CO}, 32'd1);
        go(); #1;
        ck_out("o_done", 4'b0010);
        for (int i = 0; i < 4; i++) begin
            go(); #1;
            ck_out("o_idle", 4'b0000);
        end

        // ---------------- EN gating: RELOAD=2 PSC=0, EN low 5 cycles ----------------
        do_reset();
        MODE = 1'b1; RELOAD = 16'd2; PSC = 8'd0; START = 1'b1;
        go(); START = 1'b0; #1;
        ck_out("e_load", 4'b1001);
        for (int i = 0; i < 3; i++) begin
            go(); #1;
            ck_out("e_run", 4'b0101);
        end
        go(); #1;
        ck_out("e_reload", 4'b1011);
        go(); #1;
        ck_out("e_run2", 4'b0101);
        for (int i = 0; i < 5; i++) begin
            go(); EN = 1'b0; #1;
            ck_out("e_frozen", 4'b0001);
        end
        go(); EN = 1'b1; #1;
        ck_out("e_resume", 4'b0101);
        go(); #1;
        ck_out("e_resume", 4'b0101);
        go(); #1;
        ck_out("e_reload2", 4'b1011);

        // ---------------- restart collides with accepted CO (one-shot) ----------------
        do_reset();
        MODE = 1'b0; RELOAD = 16'd1; PSC = 8'd0; START = 1'b1;
        go(); START = 1'b0; #1;
        ck_out("c_load", 4'b1001);
        chk("c_d", {16'd0, D}, {16'd0, 16'hFFFE});
        go(); #1;
        ck_out("c_run", 4'b0101);
        go(); START = 1'b1; RELOAD = 16'd2; #1;
        ck_out("c_co", 4'b0101);
        // START still high during LOAD: must be ignored.
        go(); #1;
        ck_out("c_reload", 4'b1011);
        chk("c_d_new", {16'd0, D}, {16'd0, 16'hFFFD});
        go(); START = 1'b0; #1;
        ck_out("c_run_new", 4'b0101);
        for (int i = 0; i < 2; i++) begin
            go(); #1;
            ck_out("c_run_new", 4'b0101);
        end
        go(); #1;
        ck_out("c_done", 4'b0010);
        go(); #1;
        ck_out("c_idle", 4'b0000);

        // ---------------- reset mid-run at p=PSC-1 ----------------
        do_reset();
        MODE = 1'b1; RELOAD = 16'd3; PSC = 8'd3; START = 1'b1;
        go(); START = 1'b0; #1;
        ck_out("r_load", 4'b1001);
        go(); #1;
        ck_out("r_run_p0", 4'b0001);
        go(); #1;
        ck_out("r_run_p1", 4'b0001);
        go(); RST = 1'b1; #1;
        ck_out("r_run_p2", 4'b0001);
        go(); RST = 1'b0;
        MODE = 1'b0; RELOAD = 16'd0; PSC = 8'd0; START = 1'b1; #1;
        ck_out("r_after_rst", 4'b0000);
        chk("r_after_rst_d", {16'd0, D}, 32'd0);
        go(); START = 1'b0; #1;
        ck_out("r_load2", 4'b1001);
        chk("r_d2", {16'd0, D}, {16'd0, 16'hFFFF});
        go(); #1;
        ck_out("r_run2", 4'b0101);
        go(); #1;
        ck_out("r_done2", 4'b0010);
        go(); #1;
        ck_out("r_idle2", 4'b0000);

`ifdef CTR_RELOAD_OVR_EN
        // ---------------- overrun: two IRQs without ACK ----------------
        do_reset();
        MODE = 1'b1; RELOAD = 16'd0; PSC = 8'd0; START = 1'b1;
        go(); START = 1'b0;      // LOAD
        go();                    // RUN, CO accepted
        go(); #1;                // LOAD, first IRQ
        ck_out("v_irq1", 4'b1011);
        chk("v_ovr_first", {31'd0, OVR}, 32'd0);
        go();                    // RUN
        go(); #1;                // LOAD, second IRQ
        ck_out("v_irq2", 4'b1011);
        go(); IRQ_ACK = 1'b1; #1;
        chk("v_ovr_set", {31'd0, OVR}, 32'd1);
        go(); IRQ_ACK = 1'b0; #1;
        chk("v_ovr_sticky", {31'd0, OVR}, 32'd1);

        // ---------------- ACK between IRQs: no overrun ----------------
        do_reset();
        MODE = 1'b1; RELOAD = 16'd0; PSC = 8'd0; START = 1'b1;
        go(); START = 1'b0;      // LOAD
        go();                    // RUN
        go();                    // LOAD, first IRQ
        go(); IRQ_ACK = 1'b1;    // RUN, acknowledge
        go(); IRQ_ACK = 1'b0; #1;// LOAD, second IRQ
        ck_out("a_irq2", 4'b1011);
        go(); #1;
        chk("a_ovr_clear", {31'd0, OVR}, 32'd0);
        go(); #1;
        chk("a_ovr_clear2", {31'd0, OVR}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
